// File: rtl/sc_button_debounce_if.sv
// Pushbutton bus: raw active-low pin levels in, debounced active-low levels out
// toward the point state machine.
interface sc_button_debounce_if;
   logic SC_BUTTONDEBOUNCE_startButton_InLow;
   logic SC_BUTTONDEBOUNCE_upButton_InLow;
   logic SC_BUTTONDEBOUNCE_downButton_InLow;
   logic SC_BUTTONDEBOUNCE_leftButton_InLow;
   logic SC_BUTTONDEBOUNCE_rightButton_InLow;
   logic SC_BUTTONDEBOUNCE_startButton_OutLow;
   logic SC_BUTTONDEBOUNCE_upButton_OutLow;
   logic SC_BUTTONDEBOUNCE_downButton_OutLow;
   logic SC_BUTTONDEBOUNCE_leftButton_OutLow;
   logic SC_BUTTONDEBOUNCE_rightButton_OutLow;

   modport master (
      output SC_BUTTONDEBOUNCE_startButton_InLow,
      output SC_BUTTONDEBOUNCE_upButton_InLow,
      output SC_BUTTONDEBOUNCE_downButton_InLow,
      output SC_BUTTONDEBOUNCE_leftButton_InLow,
      output SC_BUTTONDEBOUNCE_rightButton_InLow,
      input  SC_BUTTONDEBOUNCE_startButton_OutLow,
      input  SC_BUTTONDEBOUNCE_upButton_OutLow,
      input  SC_BUTTONDEBOUNCE_downButton_OutLow,
      input  SC_BUTTONDEBOUNCE_leftButton_OutLow,
      input  SC_BUTTONDEBOUNCE_rightButton_OutLow
   );

   modport slave (
      input  SC_BUTTONDEBOUNCE_startButton_InLow,
      input  SC_BUTTONDEBOUNCE_upButton_InLow,
      input  SC_BUTTONDEBOUNCE_downButton_InLow,
      input  SC_BUTTONDEBOUNCE_leftButton_InLow,
      input  SC_BUTTONDEBOUNCE_rightButton_InLow,
      output SC_BUTTONDEBOUNCE_startButton_OutLow,
      output SC_BUTTONDEBOUNCE_upButton_OutLow,
      output SC_BUTTONDEBOUNCE_downButton_OutLow,
      output SC_BUTTONDEBOUNCE_leftButton_OutLow,
      output SC_BUTTONDEBOUNCE_rightButton_OutLow
   );
endinterface

// File: rtl/sc_button_debounce.sv
// Five-channel pushbutton debouncer (start, up, down, left, right), active-low levels.
// Define SC_BUTTONDEBOUNCE_AUTOREPEAT_EN to add held-press autorepeat on the four direction channels.
module sc_button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input logic                 SC_STATEMACHINEPOINT_CLOCK_50,
   input logic                 SC_STATEMACHINEPOINT_RESET_InHigh,
   sc_button_debounce_if.slave btn
);
   localparam int CH = 5;
   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PENDING, GAP} state_t;

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_CYCLES < 2) begin : g_param_check
      $error("sc_button_debounce: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
   end

   logic [CH-1:0] raw;
   logic [CH-1:0] sync_p0;
   logic [CH-1:0] sync_p1;
   logic [CH-1:0] filt;

   // Channel order: 0 start, 1 up, 2 down, 3 left, 4 right
   assign raw = {btn.SC_BUTTONDEBOUNCE_rightButton_InLow,
                 btn.SC_BUTTONDEBOUNCE_leftButton_InLow,
                 btn.SC_BUTTONDEBOUNCE_downButton_InLow,
                 btn.SC_BUTTONDEBOUNCE_upButton_InLow,
                 btn.SC_BUTTONDEBOUNCE_startButton_InLow};

   // Stage p0/p1: two-flop synchronizer, released level during reset
   always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
      if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
         sync_p0 <= '1;
         sync_p1 <= '1;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t      state;
      logic [19:0] cnt;
      logic        out_q;
      logic        synced;

      assign synced  = sync_p1[i];
      assign filt[i] = out_q;

`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
      localparam bit REPEATS = (i != 0);
      localparam logic [23:0] RP_LAST = 24'(REPEAT_CYCLES - 1);
      logic [23:0] rpt;
      logic        gap;

      // Stage p2: filter state, gap forces the output released for two cycles
      always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
         if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= 1'b1;
            rpt   <= '0;
            gap   <= 1'b0;
         end else if (state == GAP) begin
            cnt <= '0;
            if (synced) begin
               // Released during the gap: output already reads released
               state <= IDLE;
               gap   <= 1'b0;
            end else if (gap) begin
               out_q <= 1'b0;
               gap   <= 1'b0;
               state <= IDLE;
            end else begin
               gap <= 1'b1;
            end
         end else if (synced != out_q) begin
            if (out_q) rpt <= '0;
            if (state == PENDING && cnt == DB_LAST) begin
               out_q <= synced;
               cnt   <= '0;
               state <= IDLE;
            end else begin
               cnt   <= cnt + 20'd1;
               state <= PENDING;
            end
         end else begin
            cnt   <= '0;
            state <= IDLE;
            if (REPEATS && !out_q) begin
               if (rpt == RP_LAST) begin
                  out_q <= 1'b1;
                  rpt   <= '0;
                  gap   <= 1'b0;
                  state <= GAP;
               end else begin
                  rpt <= rpt + 24'd1;
               end
            end else begin
               rpt <= '0;
            end
         end
      end
`else
      // Stage p2: filter state, commit after DEBOUNCE_CYCLES consecutive differing cycles
      always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
         if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state <= IDLE;
            cnt   <= '0;
            out_q <= 1'b1;
         end else if (synced != out_q) begin
            if (state == PENDING && cnt == DB_LAST) begin
               out_q <= synced;
               cnt   <= '0;
               state <= IDLE;
            end else begin
               cnt   <= cnt + 20'd1;
               state <= PENDING;
            end
         end else begin
            cnt   <= '0;
            state <= IDLE;
         end
      end
`endif
   end

   assign btn.SC_BUTTONDEBOUNCE_startButton_OutLow = filt[0];
   assign btn.SC_BUTTONDEBOUNCE_upButton_OutLow    = filt[1];
   assign btn.SC_BUTTONDEBOUNCE_downButton_OutLow  = filt[2];
   assign btn.SC_BUTTONDEBOUNCE_leftButton_OutLow  = filt[3];
   assign btn.SC_BUTTONDEBOUNCE_rightButton_OutLow = filt[4];

endmodule

// File: tb/tb_sc_button_debounce.sv
// Bench for sc_button_debounce: directed latency/glitch/reset cases plus random presses
// checked against a sample-history reference model.
`timescale 1ns/1ps
module tb_sc_button_debounce;
   localparam int DB = 4;
   localparam int RP = 10;
`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] raw = 5'h00;
   logic [4:0] obs;
   int         total = 0;
   int         bad = 0;

   logic [4:0] seen_q[$];
   logic [4:0] mout;
   int         run[5];

   sc_button_debounce_if bus();

   assign bus.SC_BUTTONDEBOUNCE_startButton_InLow = raw[0];
   assign bus.SC_BUTTONDEBOUNCE_upButton_InLow    = raw[1];
   assign bus.SC_BUTTONDEBOUNCE_downButton_InLow  = raw[2];
   assign bus.SC_BUTTONDEBOUNCE_leftButton_InLow  = raw[3];
   assign bus.SC_BUTTONDEBOUNCE_rightButton_InLow = raw[4];
   assign obs = {bus.SC_BUTTONDEBOUNCE_rightButton_OutLow,
                 bus.SC_BUTTONDEBOUNCE_leftButton_OutLow,
                 bus.SC_BUTTONDEBOUNCE_downButton_OutLow,
                 bus.SC_BUTTONDEBOUNCE_upButton_OutLow,
                 bus.SC_BUTTONDEBOUNCE_startButton_OutLow};

   sc_button_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
      .SC_STATEMACHINEPOINT_CLOCK_50    (clk),
      .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
      .btn                              (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: the output flips once the last DB synced samples all disagree with it;
   // synced at an edge is the raw level seen two edges earlier.
   task automatic model_reset();
      seen_q = '{5'h1f, 5'h1f};
      mout = 5'h1f;
      for (int c = 0; c < 5; c++) run[c] = 0;
   endtask

   task automatic model_edge();
      logic [4:0] pre;
      pre = seen_q.pop_front();
      seen_q.push_back(raw);
      for (int c = 0; c < 5; c++) begin
         if (pre[c] != mout[c]) begin
            run[c]++;
            if (run[c] == DB) begin
               mout[c] = pre[c];
               run[c] = 0;
            end
         end else begin
            run[c] = 0;
         end
      end
   endtask

   task automatic step(input bit check_model);
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      if (check_model) begin
         for (int c = 0; c < 5; c++)
            if (c == 0 || !AR) chk($sformatf("model_ch%0d", c), obs[c], mout[c]);
      end
   endtask

   task automatic pulse_reset(input int cycles);
      rst = 1'b1;
      model_reset();
      #1;
      chk("reset_async", obs, 5'h1f);
      repeat (cycles) step(1'b0);
      chk("reset_hold", obs, 5'h1f);
      rst = 1'b0;
   endtask

   task automatic expect_commit(input string tag, input logic [4:0] from, input logic [4:0] to);
      for (int e = 1; e <= DB + 2; e++) begin
         step(1'b1);
         chk(tag, obs, (e < DB + 2) ? from : to);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) step(1'b1);
   endtask

   initial begin
      model_reset();
      // Reset with all buttons pressed
      repeat (3) step(1'b0);
      chk("reset_out", obs, 5'h1f);
      rst = 1'b0;
      expect_commit("reset_release", 5'h1f, 5'h00);
      raw = 5'h1f;
      expect_commit("release_all", 5'h00, 5'h1f);
      settle(4);

      // Clean press and release on up
      raw[1] = 1'b0;
      expect_commit("up_press", 5'h1f, 5'h1d);
      raw[1] = 1'b1;
      expect_commit("up_release", 5'h1d, 5'h1f);
      settle(4);

      // Three-cycle glitch on left
      raw[3] = 1'b0;
      repeat (3) begin
         step(1'b1);
         chk("glitch_lo", obs, 5'h1f);
      end
      raw[3] = 1'b1;
      repeat (8) begin
         step(1'b1);
         chk("glitch_hi", obs, 5'h1f);
      end
      chk("glitch_cnt", dut.g_ch[3].cnt, 0);

      // Start and right together
      raw[0] = 1'b0;
      raw[4] = 1'b0;
      expect_commit("simul_press", 5'h1f, 5'h0e);
      raw[0] = 1'b1;
      raw[4] = 1'b1;
      expect_commit("simul_release", 5'h0e, 5'h1f);
      settle(4);

      // Reset in the middle of a pending press on down
      raw[2] = 1'b0;
      step(1'b1);
      step(1'b1);
      pulse_reset(2);
      expect_commit("rst_mid_press", 5'h1f, 5'h1b);
      raw[2] = 1'b1;
      expect_commit("rst_mid_release", 5'h1b, 5'h1f);
      settle(4);

`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
      // Up and start held: up repeats with a 2-cycle gap every RP+2 cycles, start never does
      raw[1] = 1'b0;
      raw[0] = 1'b0;
      for (int e = 1; e <= 46; e++) begin
         step(1'b1);
         chk("rep_up", obs[1], (e < DB + 2) ? 1'b1 : (((e - (DB + 2)) % (RP + 2)) >= RP));
         chk("rep_start", obs[0], (e < DB + 2) ? 1'b1 : 1'b0);
      end
      raw[1] = 1'b1;
      raw[0] = 1'b1;
      repeat (DB + 6) step(1'b0);
      chk("rep_released", obs, 5'h1f);
      model_reset();
      pulse_reset(1);
`endif

      // Random presses, bounces and occasional resets
      for (int n = 0; n < 800; n++) begin
         for (int c = 0; c < 5; c++)
            if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
         if ($urandom_range(0, 149) == 0) pulse_reset(1 + $urandom_range(0, 1));
         else step(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
